// File: rtl/flash_load_scheduler_pkg.sv
// Shared definitions for the image-flash load path.
// Holds the scheduler state encoding, flash geometry constants and the
// helper that turns (image, kind, page) into a 22-bit flash byte address.
package bd8_flash_pkg;

  localparam int IMAGE_W         = 3;
  localparam int PAGE_W          = 12;
  localparam int FLASH_ADDR_W    = 22;
  localparam int PAGE_SLOT_SHIFT = 6;
  localparam int BOOT_REGION_BIT = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Each image owns a 512 KiB window (top three address bits). The lower
  // half holds 64-byte page slots, the upper half starts the bootloader.
  function automatic logic [FLASH_ADDR_W-1:0] build_flash_addr(
    input logic [IMAGE_W-1:0] image,
    input logic               kind,
    input logic [PAGE_W-1:0]  page
  );
    logic [FLASH_ADDR_W-1:0] addr;
    addr = '0;
    addr[FLASH_ADDR_W-1 -: IMAGE_W] = image;
    addr[BOOT_REGION_BIT]           = kind;
    if (!kind) begin
      addr[PAGE_SLOT_SHIFT +: PAGE_W] = page;
    end
    return addr;
  endfunction

endpackage

// File: rtl/flash_load_scheduler_if.sv
// Request/loader bus of the flash load scheduler.
//   Bubble side : image_number, load_page, page_number, load_bootloader,
//                 page_ready, boot_ready, busy, timeout_error
//   Loader side : loader_start, loader_address, loader_kind, loader_abort,
//                 loader_done
// master = environment (bubble interface + SPI loader), slave = scheduler.
interface flash_load_scheduler_if;
  import bd8_flash_pkg::*;

  logic [IMAGE_W-1:0]      image_number;
  logic                    load_page;
  logic [PAGE_W-1:0]       page_number;
  logic                    load_bootloader;
  logic                    loader_done;
  logic                    loader_start;
  logic [FLASH_ADDR_W-1:0] loader_address;
  logic                    loader_kind;
  logic                    loader_abort;
  logic                    busy;
  logic                    page_ready;
  logic                    boot_ready;
  logic                    timeout_error;

  modport master (
    output image_number, load_page, page_number, load_bootloader, loader_done,
    input  loader_start, loader_address, loader_kind, loader_abort,
           busy, page_ready, boot_ready, timeout_error
  );

  modport slave (
    input  image_number, load_page, page_number, load_bootloader, loader_done,
    output loader_start, loader_address, loader_kind, loader_abort,
           busy, page_ready, boot_ready, timeout_error
  );

endinterface

// File: rtl/flash_load_scheduler_watchdog.sv
// load_watchdog: saturating cycle counter with clear and enable.
//   master_clock in  clock
//   power_good   in  asynchronous active-low reset
//   i_clear      in  force count to zero (wins over enable)
//   i_enable     in  count one cycle
//   o_expired    out count has reached LIMIT
module load_watchdog #(
  parameter int          CNT_W = 16,
  parameter int unsigned LIMIT = 65535
) (
  input  logic master_clock,
  input  logic power_good,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  assign o_expired = (r_count >= LIMIT_C);

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/flash_load_scheduler.sv
// flash_load_scheduler: arbitrates page and bootloader load requests,
// issues one load at a time to the SPI loader, skips reloading the page
// already in the bubble buffer and recovers from a loader that hangs.
//   master_clock  in  clock
//   power_good    in  asynchronous active-low reset
//   bus           slave modport of flash_load_scheduler_if
module flash_load_scheduler
  import bd8_flash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   master_clock,
  input  logic                   power_good,
  flash_load_scheduler_if.slave  bus
);

  state_e                  r_state;
  logic                    r_boot_pend;
  logic                    r_page_pend;
  logic [PAGE_W-1:0]       r_pend_page;
  logic                    r_kind;
  logic [PAGE_W-1:0]       r_issue_page;
  logic [IMAGE_W-1:0]      r_issue_image;
  logic [FLASH_ADDR_W-1:0] r_addr;
  logic                    r_page_ready;
  logic                    r_boot_ready;
  logic                    r_abort;
  logic                    r_timeout_error;
  logic                    r_cache_valid;
  logic [IMAGE_W-1:0]      r_cache_image;
  logic [PAGE_W-1:0]       r_cache_page;
  logic [IMAGE_W-1:0]      r_image_q;

  logic                    w_busy;
  logic                    w_cache_hit;
  logic                    w_wd_expired;
  logic [FLASH_ADDR_W-1:0] w_issue_addr;

  assign w_busy       = (r_state != ST_IDLE);
  assign w_cache_hit  = r_cache_valid && (r_cache_image == bus.image_number)
                        && (r_cache_page == r_pend_page);
  // image_number is taken live during ISSUE, then the address is held.
  assign w_issue_addr = build_flash_addr(bus.image_number, r_kind, r_issue_page);

  assign bus.loader_start   = (r_state == ST_ISSUE);
  assign bus.loader_address = (r_state == ST_ISSUE) ? w_issue_addr : r_addr;
  assign bus.loader_kind    = r_kind;
  assign bus.loader_abort   = r_abort;
  assign bus.busy           = w_busy;
  assign bus.page_ready     = r_page_ready;
  assign bus.boot_ready     = r_boot_ready;
  assign bus.timeout_error  = r_timeout_error;

  // Held at zero while idle and counting from the ISSUE cycle, so the
  // abort pulse (registered one cycle after expiry) lands exactly
  // TIMEOUT_CYCLES cycles after loader_start.
  load_watchdog #(
    .CNT_W (16),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_watchdog (
    .master_clock (master_clock),
    .power_good   (power_good),
    .i_clear      (!w_busy),
    .i_enable     (w_busy),
    .o_expired    (w_wd_expired)
  );

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_state         <= ST_IDLE;
      r_boot_pend     <= 1'b0;
      r_page_pend     <= 1'b0;
      r_pend_page     <= '0;
      r_kind          <= 1'b0;
      r_issue_page    <= '0;
      r_issue_image   <= '0;
      r_addr          <= '0;
      r_page_ready    <= 1'b0;
      r_boot_ready    <= 1'b0;
      r_abort         <= 1'b0;
      r_timeout_error <= 1'b0;
      r_cache_valid   <= 1'b0;
      r_cache_image   <= '0;
      r_cache_page    <= '0;
      r_image_q       <= '0;
    end else begin
      r_page_ready <= 1'b0;
      r_boot_ready <= 1'b0;
      r_abort      <= 1'b0;
      r_image_q    <= bus.image_number;

      if (bus.load_page || bus.load_bootloader) begin
        r_timeout_error <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          // The served request is captured and its flag dropped here, so a
          // request arriving during ISSUE is never lost.
          if (r_boot_pend) begin
            r_kind      <= 1'b1;
            r_boot_pend <= 1'b0;
            r_state     <= ST_ISSUE;
          end else if (r_page_pend) begin
            r_page_pend <= 1'b0;
            if (w_cache_hit) begin
              r_page_ready <= 1'b1;
            end else begin
              r_kind       <= 1'b0;
              r_issue_page <= r_pend_page;
              r_state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_addr        <= w_issue_addr;
          r_issue_image <= bus.image_number;
          if (r_kind) begin
            r_cache_valid <= 1'b0;
          end
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.loader_done) begin
            if (r_kind) begin
              r_boot_ready <= 1'b1;
            end else begin
              r_page_ready  <= 1'b1;
              r_cache_valid <= 1'b1;
              r_cache_image <= r_issue_image;
              r_cache_page  <= r_issue_page;
            end
            r_state <= ST_IDLE;
          end else if (w_wd_expired) begin
            r_abort         <= 1'b1;
            r_timeout_error <= 1'b1;
            r_cache_valid   <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // New requests override the clearing above (latest page wins).
      if (bus.load_bootloader) begin
        r_boot_pend <= 1'b1;
      end
      if (bus.load_page) begin
        r_page_pend <= 1'b1;
        r_pend_page <= bus.page_number;
      end

      // Any image switch makes the buffered page meaningless.
      if (bus.image_number != r_image_q) begin
        r_cache_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flash_load_scheduler.sv
// Directed bench for flash_load_scheduler with a shortened watchdog.
module tb_flash_load_scheduler;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  flash_load_scheduler_if bus();

  flash_load_scheduler #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .master_clock (clk),
    .power_good   (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic req_page(input logic [11:0] page);
    bus.page_number = page;
    bus.load_page   = 1'b1;
    tick();
    bus.load_page   = 1'b0;
  endtask

  task automatic done_pulse();
    bus.loader_done = 1'b1;
    tick();
    bus.loader_done = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n               = 1'b0;
    bus.image_number    = 3'd0;
    bus.load_page       = 1'b0;
    bus.page_number     = 12'h000;
    bus.load_bootloader = 1'b0;
    bus.loader_done     = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_start", 32'(bus.loader_start), 32'h0);
    check("rst_addr", 32'(bus.loader_address), 32'h0);
    check("rst_kind", 32'(bus.loader_kind), 32'h0);
    check("rst_abort", 32'(bus.loader_abort), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_pready", 32'(bus.page_ready), 32'h0);
    check("rst_bready", 32'(bus.boot_ready), 32'h0);
    check("rst_terr", 32'(bus.timeout_error), 32'h0);
    rst_n = 1'b1;
    tick();

    // First page load, image 2, page 0x123
    bus.image_number = 3'd2;
    req_page(12'h123);
    check("p1_nostart_early", 32'(bus.loader_start), 32'h0);
    tick();
    $display("txn page_load image=2 page=0x123 addr=0x%0h", bus.loader_address);
    check("p1_start", 32'(bus.loader_start), 32'h1);
    check("p1_addr", 32'(bus.loader_address), 32'h1048C0);
    check("p1_kind", 32'(bus.loader_kind), 32'h0);
    check("p1_busy", 32'(bus.busy), 32'h1);
    repeat (9) tick();
    check("p1_start_low", 32'(bus.loader_start), 32'h0);
    check("p1_busy_wait", 32'(bus.busy), 32'h1);
    check("p1_addr_held", 32'(bus.loader_address), 32'h1048C0);
    done_pulse();
    check("p1_ready", 32'(bus.page_ready), 32'h1);
    check("p1_busy_low", 32'(bus.busy), 32'h0);
    tick();
    check("p1_ready_pulse", 32'(bus.page_ready), 32'h0);

    // Cache hit on the same page and image
    req_page(12'h123);
    check("hit_ready_early", 32'(bus.page_ready), 32'h0);
    tick();
    $display("txn page_hit image=2 page=0x123 ready=%0b", bus.page_ready);
    check("hit_ready", 32'(bus.page_ready), 32'h1);
    check("hit_nostart", 32'(bus.loader_start), 32'h0);
    check("hit_busy", 32'(bus.busy), 32'h0);
    tick();
    check("hit_ready_pulse", 32'(bus.page_ready), 32'h0);
    check("hit_nostart2", 32'(bus.loader_start), 32'h0);

    // Image change forces a reload
    bus.image_number = 3'd3;
    req_page(12'h123);
    tick();
    $display("txn page_load image=3 page=0x123 addr=0x%0h", bus.loader_address);
    check("img3_start", 32'(bus.loader_start), 32'h1);
    check("img3_addr", 32'(bus.loader_address), 32'h1848C0);
    tick();
    done_pulse();
    check("img3_ready", 32'(bus.page_ready), 32'h1);
    tick();

    // Simultaneous page + bootloader: boot first
    bus.image_number    = 3'd2;
    bus.page_number     = 12'h010;
    bus.load_page       = 1'b1;
    bus.load_bootloader = 1'b1;
    tick();
    bus.load_page       = 1'b0;
    bus.load_bootloader = 1'b0;
    tick();
    $display("txn boot_load image=2 addr=0x%0h kind=%0b", bus.loader_address, bus.loader_kind);
    check("boot_start", 32'(bus.loader_start), 32'h1);
    check("boot_addr", 32'(bus.loader_address), 32'h140000);
    check("boot_kind", 32'(bus.loader_kind), 32'h1);
    repeat (2) tick();
    done_pulse();
    check("boot_ready", 32'(bus.boot_ready), 32'h1);
    check("boot_no_pready", 32'(bus.page_ready), 32'h0);
    check("boot_busy_low", 32'(bus.busy), 32'h0);
    tick();
    $display("txn page_load image=2 page=0x010 addr=0x%0h", bus.loader_address);
    check("after_boot_start", 32'(bus.loader_start), 32'h1);
    check("after_boot_addr", 32'(bus.loader_address), 32'h100400);
    check("after_boot_kind", 32'(bus.loader_kind), 32'h0);
    tick();
    done_pulse();
    check("after_boot_ready", 32'(bus.page_ready), 32'h1);
    tick();

    // Requests during WAIT: latest page wins
    req_page(12'h020);
    tick();
    check("w_start", 32'(bus.loader_start), 32'h1);
    check("w_addr", 32'(bus.loader_address), 32'h100800);
    tick();
    req_page(12'h005);
    req_page(12'h006);
    tick();
    done_pulse();
    check("w_ready", 32'(bus.page_ready), 32'h1);
    tick();
    $display("txn page_load image=2 page=0x006 addr=0x%0h", bus.loader_address);
    check("w_latest_start", 32'(bus.loader_start), 32'h1);
    check("w_latest_addr", 32'(bus.loader_address), 32'h100180);
    tick();
    done_pulse();
    check("w_latest_ready", 32'(bus.page_ready), 32'h1);
    tick();
    check("w_no_old_page", 32'(bus.loader_start), 32'h0);
    check("w_idle", 32'(bus.busy), 32'h0);

    // Timeout after exactly 100 cycles
    req_page(12'h077);
    tick();
    check("to_start", 32'(bus.loader_start), 32'h1);
    check("to_addr", 32'(bus.loader_address), 32'h101DC0);
    repeat (99) tick();
    check("to_abort_early", 32'(bus.loader_abort), 32'h0);
    check("to_busy_99", 32'(bus.busy), 32'h1);
    tick();
    $display("txn timeout abort=%0b terr=%0b", bus.loader_abort, bus.timeout_error);
    check("to_abort", 32'(bus.loader_abort), 32'h1);
    check("to_terr", 32'(bus.timeout_error), 32'h1);
    check("to_busy_low", 32'(bus.busy), 32'h0);
    tick();
    check("to_abort_pulse", 32'(bus.loader_abort), 32'h0);
    check("to_terr_sticky", 32'(bus.timeout_error), 32'h1);

    // Previously cached page must reload after a timeout
    req_page(12'h006);
    check("to_terr_cleared", 32'(bus.timeout_error), 32'h0);
    tick();
    $display("txn page_reload image=2 page=0x006 addr=0x%0h", bus.loader_address);
    check("to_reload_start", 32'(bus.loader_start), 32'h1);
    check("to_reload_addr", 32'(bus.loader_address), 32'h100180);
    check("to_reload_nohit", 32'(bus.page_ready), 32'h0);

    // Reset during WAIT
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_start", 32'(bus.loader_start), 32'h0);
    check("mid_rst_addr", 32'(bus.loader_address), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    done_pulse();
    $display("txn stray_done ready=%0b busy=%0b", bus.page_ready, bus.busy);
    check("stray_done_pready", 32'(bus.page_ready), 32'h0);
    check("stray_done_bready", 32'(bus.boot_ready), 32'h0);
    check("stray_done_busy", 32'(bus.busy), 32'h0);
    tick();
    check("stray_done_nostart", 32'(bus.loader_start), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
